// File: rtl/adc_acq_pkg.sv
// Shared types and default constants for the ADC acquisition sequencer.
package adc_acq_pkg;

    localparam int DEF_ADC_WIDTH  = 16;
    localparam int DEF_ADDR_WIDTH = 12;

    // Sequencer states; the encoding is visible to software via sts_state.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_WAIT = 3'd2,
        ST_POST = 3'd3,
        ST_DONE = 3'd4
    } acq_state_e;

    // Trigger source selection as written by the register file.
    typedef enum logic [1:0] {
        TRIG_SW    = 2'd0,
        TRIG_EXT   = 2'd1,
        TRIG_LEVEL = 2'd2,
        TRIG_NONE  = 2'd3
    } trig_src_e;

endpackage

// File: rtl/adc_acq_trig_detect.sv
// Trigger qualification: external rising edge and signed level crossing.
module adc_acq_trig_detect
    import adc_acq_pkg::*;
#(
    parameter int ADC_WIDTH = DEF_ADC_WIDTH
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_clear,
    input  logic                        i_track,
    input  logic                        i_detect_en,
    input  logic                        i_adc_valid,
    input  logic signed [ADC_WIDTH-1:0] i_adc_data,
    input  logic                        i_ext_trig,
    input  logic                        i_sw_trig,
    input  trig_src_e                   i_src,
    input  logic signed [ADC_WIDTH-1:0] i_level,
    output logic                        o_trig
);

    logic                        r_ext_d;
    logic                        r_prev_valid;
    logic signed [ADC_WIDTH-1:0] r_prev_sample;
    logic                        w_ext_rise;
    logic                        w_level_cross;

    // Edge history runs every cycle; previous sample follows captured samples only.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ext_d       <= 1'b0;
            r_prev_valid  <= 1'b0;
            r_prev_sample <= '0;
        end else begin
            r_ext_d <= i_ext_trig;
            if (i_clear) begin
                r_prev_valid <= 1'b0;
            end else if (i_track && i_adc_valid) begin
                r_prev_valid  <= 1'b1;
                r_prev_sample <= i_adc_data;
            end
        end
    end

    // Select the qualified trigger for the latched source.
    always_comb begin
        w_ext_rise    = i_ext_trig & ~r_ext_d;
        w_level_cross = i_adc_valid & r_prev_valid &
                        (r_prev_sample < i_level) & (i_adc_data >= i_level);
        o_trig        = 1'b0;
        if (i_detect_en) begin
            case (i_src)
                TRIG_SW:    o_trig = i_sw_trig;
                TRIG_EXT:   o_trig = w_ext_rise;
                TRIG_LEVEL: o_trig = w_level_cross;
                default:    o_trig = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/adc_acq_sequencer.sv
// Pre/post-trigger capture sequencer writing ADC samples into a ring buffer.
module adc_acq_sequencer
    import adc_acq_pkg::*;
#(
    parameter int ADC_WIDTH  = DEF_ADC_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  s00_axi_aclk,
    input  logic                  s00_axi_aresetn,
    input  logic [ADC_WIDTH-1:0]  adc_data,
    input  logic                  adc_valid,
    input  logic                  ext_trig,
    input  logic                  cfg_arm,
    input  logic                  cfg_abort,
    input  logic                  cfg_sw_trig,
    input  logic [1:0]            cfg_trig_src,
    input  logic [ADC_WIDTH-1:0]  cfg_level,
    input  logic [ADDR_WIDTH-1:0] cfg_pretrig,
    input  logic [ADDR_WIDTH-1:0] cfg_posttrig,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [ADC_WIDTH-1:0]  bram_din,
    output logic [2:0]            sts_state,
    output logic                  sts_busy,
    output logic                  sts_done,
    output logic [ADDR_WIDTH-1:0] sts_trig_addr,
    output logic                  irq
);

    acq_state_e                  r_state;
    acq_state_e                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]       r_wr_ptr, w_wr_ptr_nxt;
    logic [ADDR_WIDTH-1:0]       r_pre_cnt, w_pre_cnt_nxt;
    logic [ADDR_WIDTH-1:0]       r_post_cnt, w_post_cnt_nxt;
    logic [ADDR_WIDTH-1:0]       r_trig_addr, w_trig_addr_nxt;
    trig_src_e                   r_src;
    logic signed [ADC_WIDTH-1:0] r_level;
    logic [ADDR_WIDTH-1:0]       r_pretrig;
    logic [ADDR_WIDTH-1:0]       r_posttrig;
    logic                        r_bram_we;
    logic [ADDR_WIDTH-1:0]       r_bram_addr;
    logic [ADC_WIDTH-1:0]        r_bram_din;
    logic                        r_irq;

    logic                        w_busy;
    logic                        w_in_wait;
    logic                        w_write;
    logic                        w_trig;
    logic                        w_load_cfg;
    logic                        w_irq_nxt;
    logic [ADDR_WIDTH-1:0]       w_pre_inc;
    logic [ADDR_WIDTH-1:0]       w_post_target;

    assign w_busy        = (r_state == ST_PRE) || (r_state == ST_WAIT) || (r_state == ST_POST);
    assign w_in_wait     = (r_state == ST_WAIT);
    assign w_write       = w_busy && adc_valid && !cfg_abort;
    assign w_post_target = (r_posttrig == '0) ? ADDR_WIDTH'(1) : r_posttrig;
    assign w_pre_inc     = r_pre_cnt + ADDR_WIDTH'(adc_valid);

    adc_acq_trig_detect #(
        .ADC_WIDTH (ADC_WIDTH)
    ) u_trig_detect (
        .i_clk       (s00_axi_aclk),
        .i_rst_n     (s00_axi_aresetn),
        .i_clear     (w_load_cfg),
        .i_track     (w_busy),
        .i_detect_en (w_in_wait),
        .i_adc_valid (adc_valid),
        .i_adc_data  (adc_data),
        .i_ext_trig  (ext_trig),
        .i_sw_trig   (cfg_sw_trig),
        .i_src       (r_src),
        .i_level     (r_level),
        .o_trig      (w_trig)
    );

    // Next-state, pointer and counter decisions; abort overrides everything.
    always_comb begin
        w_state_nxt     = r_state;
        w_wr_ptr_nxt    = r_wr_ptr;
        w_pre_cnt_nxt   = r_pre_cnt;
        w_post_cnt_nxt  = r_post_cnt;
        w_trig_addr_nxt = r_trig_addr;
        w_load_cfg      = 1'b0;

        if (w_write) begin
            w_wr_ptr_nxt = r_wr_ptr + 1'b1;
        end

        if (cfg_abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (cfg_arm) begin
                        w_state_nxt     = ST_PRE;
                        w_wr_ptr_nxt    = '0;
                        w_pre_cnt_nxt   = '0;
                        w_post_cnt_nxt  = '0;
                        w_trig_addr_nxt = '0;
                        w_load_cfg      = 1'b1;
                    end
                end
                ST_PRE: begin
                    w_pre_cnt_nxt = w_pre_inc;
                    // pretrig of zero still spends exactly one cycle in PRE
                    if ((r_pretrig == '0) || (w_pre_inc == r_pretrig)) begin
                        w_state_nxt = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_trig) begin
                        w_trig_addr_nxt = r_wr_ptr;
                        w_post_cnt_nxt  = ADDR_WIDTH'(adc_valid);
                        if (adc_valid && (w_post_target == ADDR_WIDTH'(1))) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_state_nxt = ST_POST;
                        end
                    end
                end
                ST_POST: begin
                    if (adc_valid) begin
                        w_post_cnt_nxt = r_post_cnt + 1'b1;
                        if (w_post_cnt_nxt == w_post_target) begin
                            w_state_nxt = ST_DONE;
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end

        w_irq_nxt = (w_state_nxt == ST_DONE) && (r_state != ST_DONE);
    end

    // State register.
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counters, latched configuration, buffer write port and interrupt pulse.
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            r_wr_ptr    <= '0;
            r_pre_cnt   <= '0;
            r_post_cnt  <= '0;
            r_trig_addr <= '0;
            r_src       <= TRIG_SW;
            r_level     <= '0;
            r_pretrig   <= '0;
            r_posttrig  <= '0;
            r_bram_we   <= 1'b0;
            r_bram_addr <= '0;
            r_bram_din  <= '0;
            r_irq       <= 1'b0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_pre_cnt   <= w_pre_cnt_nxt;
            r_post_cnt  <= w_post_cnt_nxt;
            r_trig_addr <= w_trig_addr_nxt;
            r_bram_we   <= w_write;
            r_irq       <= w_irq_nxt;
            if (w_write) begin
                r_bram_addr <= r_wr_ptr;
                r_bram_din  <= adc_data;
            end
            if (w_load_cfg) begin
                r_src      <= trig_src_e'(cfg_trig_src);
                r_level    <= cfg_level;
                r_pretrig  <= cfg_pretrig;
                r_posttrig <= cfg_posttrig;
            end
        end
    end

    assign bram_we       = r_bram_we;
    assign bram_addr     = r_bram_addr;
    assign bram_din      = r_bram_din;
    assign sts_state     = r_state;
    assign sts_busy      = w_busy;
    assign sts_done      = (r_state == ST_DONE);
    assign sts_trig_addr = r_trig_addr;
    assign irq           = r_irq;

endmodule

// File: tb/tb_adc_acq_sequencer.sv
// Randomized and directed bench for adc_acq_sequencer against a behavioural model.
module tb_adc_acq_sequencer;

    logic        clk;
    logic        rstn;
    logic [15:0] adc_data;
    logic        adc_valid;
    logic        ext_trig;
    logic        cfg_arm, cfg_abort, cfg_sw_trig;
    logic [1:0]  cfg_trig_src;
    logic [15:0] cfg_level;
    logic [11:0] cfg_pretrig, cfg_posttrig;

    logic        we_a, busy_a, done_a, irq_a;
    logic [11:0] addr_a, taddr_a;
    logic [15:0] din_a;
    logic [2:0]  state_a;
    logic        we_b, busy_b, done_b, irq_b;
    logic [3:0]  addr_b, taddr_b;
    logic [15:0] din_b;
    logic [2:0]  state_b;

    adc_acq_sequencer dut (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rstn),
        .adc_data(adc_data), .adc_valid(adc_valid), .ext_trig(ext_trig),
        .cfg_arm(cfg_arm), .cfg_abort(cfg_abort), .cfg_sw_trig(cfg_sw_trig),
        .cfg_trig_src(cfg_trig_src), .cfg_level(cfg_level),
        .cfg_pretrig(cfg_pretrig), .cfg_posttrig(cfg_posttrig),
        .bram_we(we_a), .bram_addr(addr_a), .bram_din(din_a),
        .sts_state(state_a), .sts_busy(busy_a), .sts_done(done_a),
        .sts_trig_addr(taddr_a), .irq(irq_a)
    );

    adc_acq_sequencer #(.ADDR_WIDTH(4)) dut4 (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rstn),
        .adc_data(adc_data), .adc_valid(adc_valid), .ext_trig(ext_trig),
        .cfg_arm(cfg_arm), .cfg_abort(cfg_abort), .cfg_sw_trig(cfg_sw_trig),
        .cfg_trig_src(cfg_trig_src), .cfg_level(cfg_level),
        .cfg_pretrig(cfg_pretrig[3:0]), .cfg_posttrig(cfg_posttrig[3:0]),
        .bram_we(we_b), .bram_addr(addr_b), .bram_din(din_b),
        .sts_state(state_b), .sts_busy(busy_b), .sts_done(done_b),
        .sts_trig_addr(taddr_b), .irq(irq_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state, index 0 = 4096-deep instance, 1 = 16-deep instance.
    int depth [2] = '{4096, 16};
    int m_phase[2], m_ptr[2], m_npre[2], m_npost[2], m_taddr[2];
    int m_lpre[2], m_lpost[2], m_src[2], m_level[2], m_prev[2];
    bit m_prevok[2], m_ext[2];
    int e_we[2], e_addr[2], e_din[2], e_irq[2];

    // Observation statistics.
    int wr_cnt[2], irq_cnt[2];
    bit wrap_seen;
    int last_addr_b;
    bit stream_on;
    int ramp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_write(input int k);
        e_we[k]   = 1;
        e_addr[k] = m_ptr[k];
        e_din[k]  = int'(adc_data);
        m_ptr[k]  = (m_ptr[k] + 1) % depth[k];
    endtask

    // Predict what the instance shows after the coming rising edge.
    task automatic model_step(input int k);
        int  old_phase;
        int  dval;
        bit  fire;
        bit  capturing;
        dval = int'($signed(adc_data));
        if (!rstn) begin
            m_phase[k] = 0; m_ptr[k] = 0; m_npre[k] = 0; m_npost[k] = 0;
            m_taddr[k] = 0; m_prevok[k] = 0; m_ext[k] = 0; m_prev[k] = 0;
            e_we[k] = 0; e_addr[k] = 0; e_din[k] = 0; e_irq[k] = 0;
            return;
        end
        e_we[k]   = 0;
        e_irq[k]  = 0;
        old_phase = m_phase[k];
        capturing = (old_phase >= 1) && (old_phase <= 3);
        if (cfg_abort) begin
            m_phase[k] = 0;
        end else if (old_phase == 0 || old_phase == 4) begin
            if (cfg_arm) begin
                m_phase[k] = 1; m_ptr[k] = 0; m_npre[k] = 0; m_npost[k] = 0;
                m_taddr[k] = 0; m_prevok[k] = 0;
                m_lpre[k]  = int'(cfg_pretrig) % depth[k];
                m_lpost[k] = int'(cfg_posttrig) % depth[k];
                if (m_lpost[k] == 0) m_lpost[k] = 1;
                m_src[k]   = int'(cfg_trig_src);
                m_level[k] = int'($signed(cfg_level));
            end
        end else if (old_phase == 1) begin
            if (adc_valid) begin
                model_write(k);
                m_npre[k]++;
            end
            if (m_lpre[k] == 0 || m_npre[k] == m_lpre[k]) m_phase[k] = 2;
        end else if (old_phase == 2) begin
            case (m_src[k])
                0: fire = cfg_sw_trig;
                1: fire = ext_trig && !m_ext[k];
                2: fire = adc_valid && m_prevok[k] && (m_prev[k] < m_level[k]) && (dval >= m_level[k]);
                default: fire = 0;
            endcase
            if (fire) m_taddr[k] = m_ptr[k];
            if (adc_valid) model_write(k);
            if (fire) begin
                m_npost[k] = adc_valid ? 1 : 0;
                m_phase[k] = (m_npost[k] >= m_lpost[k]) ? 4 : 3;
            end
        end else if (old_phase == 3) begin
            if (adc_valid) begin
                model_write(k);
                m_npost[k]++;
                if (m_npost[k] >= m_lpost[k]) m_phase[k] = 4;
            end
        end
        if (m_phase[k] == 4 && old_phase != 4) e_irq[k] = 1;
        if (capturing && adc_valid) begin
            m_prev[k]   = dval;
            m_prevok[k] = 1;
        end
        m_ext[k] = ext_trig;
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            int exp_busy;
            exp_busy = (m_phase[k] >= 1 && m_phase[k] <= 3) ? 1 : 0;
            if (k == 0) begin
                check("a_state", 32'(state_a), 32'(m_phase[0]));
                check("a_we",    32'(we_a),    32'(e_we[0]));
                check("a_addr",  32'(addr_a),  32'(e_addr[0]));
                check("a_din",   32'(din_a),   32'(e_din[0]));
                check("a_irq",   32'(irq_a),   32'(e_irq[0]));
                check("a_taddr", 32'(taddr_a), 32'(m_taddr[0]));
                check("a_busy",  32'(busy_a),  32'(exp_busy));
                check("a_done",  32'(done_a),  32'(m_phase[0] == 4));
            end else begin
                check("b_state", 32'(state_b), 32'(m_phase[1]));
                check("b_we",    32'(we_b),    32'(e_we[1]));
                check("b_addr",  32'(addr_b),  32'(e_addr[1]));
                check("b_din",   32'(din_b),   32'(e_din[1]));
                check("b_irq",   32'(irq_b),   32'(e_irq[1]));
                check("b_taddr", 32'(taddr_b), 32'(m_taddr[1]));
                check("b_busy",  32'(busy_b),  32'(exp_busy));
                check("b_done",  32'(done_b),  32'(m_phase[1] == 4));
            end
        end
        if (we_a) wr_cnt[0]++;
        if (irq_a) irq_cnt[0]++;
        if (irq_b) irq_cnt[1]++;
        if (we_b) begin
            wr_cnt[1]++;
            if (last_addr_b == 15 && addr_b == 4'd0) wrap_seen = 1;
            last_addr_b = int'(addr_b);
        end
    endtask

    task automatic tick();
        if (stream_on) begin
            adc_valid = 1'b1;
            adc_data  = 16'(ramp);
            ramp++;
        end
        model_step(0);
        model_step(1);
        @(posedge clk);
        @(negedge clk);
        compare_all();
        cfg_arm     = 1'b0;
        cfg_abort   = 1'b0;
        cfg_sw_trig = 1'b0;
    endtask

    task automatic clear_stats();
        wr_cnt  = '{0, 0};
        irq_cnt = '{0, 0};
        wrap_seen   = 0;
        last_addr_b = 0;
    endtask

    task automatic wait_state(input logic [2:0] target, input int limit, input string tag);
        int n;
        n = 0;
        while (state_a !== target && n < limit) begin
            tick();
            n++;
        end
        check(tag, 32'(state_a), 32'(target));
    endtask

    task automatic do_arm(input int pre, input int post, input int src, input int level);
        cfg_pretrig  = 12'(pre);
        cfg_posttrig = 12'(post);
        cfg_trig_src = 2'(src);
        cfg_level    = 16'(level);
        cfg_arm      = 1'b1;
        stream_on    = 0;
        adc_valid    = 1'b0;
        clear_stats();
        tick();
    endtask

    task automatic do_abort();
        stream_on = 0;
        adc_valid = 1'b0;
        cfg_abort = 1'b1;
        tick();
    endtask

    initial begin
        rstn = 1'b0; adc_data = '0; adc_valid = 1'b0; ext_trig = 1'b0;
        cfg_arm = 1'b0; cfg_abort = 1'b0; cfg_sw_trig = 1'b0;
        cfg_trig_src = 2'd0; cfg_level = '0; cfg_pretrig = '0; cfg_posttrig = '0;
        stream_on = 0; ramp = 0;
        clear_stats();
        @(negedge clk);

        // Reset values
        repeat (3) tick();
        check("rst_state", 32'(state_a), 32'd0);
        check("rst_we",    32'(we_a),    32'd0);
        check("rst_irq",   32'(irq_a),   32'd0);
        check("rst_taddr", 32'(taddr_a), 32'd0);
        rstn = 1'b1;
        repeat (2) tick();

        // Software trigger 10 cycles into WAIT on a continuous ramp
        do_arm(4, 8, 0, 0);
        ramp = 0; stream_on = 1;
        wait_state(3'd2, 20, "sw_reach_wait");
        repeat (10) tick();
        cfg_sw_trig = 1'b1;
        tick();
        check("sw_taddr", 32'(taddr_a), 32'((ramp - 1) % 4096));
        wait_state(3'd4, 20, "sw_reach_done");
        repeat (3) tick();
        check("sw_irq_cnt", 32'(irq_cnt[0]), 32'd1);
        check("sw_writes",  32'(wr_cnt[0]),  32'd22);
        check("sw_done",    32'(state_a),    32'd4);

        // Level crossing: equal-to-level first sample does not trigger
        do_arm(0, 4, 2, 100);
        adc_valid = 1'b1;
        adc_data = 16'd100; tick();
        adc_data = 16'd101; tick();
        adc_data = 16'd102; tick();
        check("lvl_eq_first", 32'(state_a), 32'd2);
        do_abort();
        check("lvl_abort", 32'(state_a), 32'd0);

        // Level crossing on ramp 90..110
        do_arm(0, 4, 2, 100);
        for (int v = 90; v <= 110; v++) begin
            adc_valid = 1'b1;
            adc_data  = 16'(v);
            tick();
            if (v == 99)  check("lvl_not_99", 32'(state_a), 32'd2);
            if (v == 100) check("lvl_at_100", 32'(state_a), 32'd3);
        end
        check("lvl_taddr", 32'(taddr_a), 32'd10);
        check("lvl_done",  32'(state_a), 32'd4);
        check("lvl_irq",   32'(irq_cnt[0]), 32'd1);

        // External edge: held high across arm and PRE must not trigger
        ext_trig = 1'b1;
        repeat (2) tick();
        do_arm(3, 3, 1, 0);
        ramp = 0; stream_on = 1;
        wait_state(3'd2, 10, "ext_reach_wait");
        repeat (5) tick();
        check("ext_held", 32'(state_a), 32'd2);
        ext_trig = 1'b0;
        repeat (2) tick();
        stream_on = 0; adc_valid = 1'b0;
        ext_trig = 1'b1;
        tick();
        check("ext_post",  32'(state_a), 32'd3);
        check("ext_taddr", 32'(taddr_a), 32'd10);
        stream_on = 1;
        wait_state(3'd4, 10, "ext_reach_done");
        ext_trig = 1'b0;

        // Abort in the same cycle as a trigger
        do_arm(1, 5, 0, 0);
        ramp = 0; stream_on = 1;
        wait_state(3'd2, 10, "abt_reach_wait");
        repeat (2) tick();
        cfg_sw_trig = 1'b1;
        cfg_abort   = 1'b1;
        tick();
        check("abt_state", 32'(state_a), 32'd0);
        check("abt_we",    32'(we_a),    32'd0);
        repeat (3) tick();
        check("abt_irq",   32'(irq_cnt[0] + irq_cnt[1]), 32'd0);
        stream_on = 0; adc_valid = 1'b0;

        // Wrap in a 16-deep buffer: pre 12, post 10
        do_arm(12, 10, 0, 0);
        ramp = 0; stream_on = 1;
        wait_state(3'd2, 20, "wrap_reach_wait");
        repeat (2) tick();
        wr_cnt = '{0, 0};
        cfg_sw_trig = 1'b1;
        tick();
        wait_state(3'd4, 20, "wrap_reach_done");
        check("wrap_post_b", 32'(wr_cnt[1]), 32'd10);
        check("wrap_post_a", 32'(wr_cnt[0]), 32'd10);
        check("wrap_seen",   32'(wrap_seen), 32'd1);
        check("wrap_taddr",  32'(taddr_b),   32'd14);
        check("wrap_done_b", 32'(state_b),   32'd4);

        // Reset mid-POST, then re-arm with pretrig 0
        do_arm(2, 20, 0, 0);
        ramp = 0; stream_on = 1;
        wait_state(3'd2, 10, "rp_reach_wait");
        cfg_sw_trig = 1'b1;
        tick();
        repeat (3) tick();
        check("rp_in_post", 32'(state_a), 32'd3);
        rstn = 1'b0;
        repeat (2) tick();
        check("rp_state", 32'(state_a), 32'd0);
        check("rp_we",    32'(we_a),    32'd0);
        check("rp_addr",  32'(addr_a),  32'd0);
        check("rp_din",   32'(din_a),   32'd0);
        check("rp_taddr", 32'(taddr_a), 32'd0);
        check("rp_busy",  32'(busy_a),  32'd0);
        rstn = 1'b1;
        do_arm(0, 3, 0, 0);
        check("rp_pre",  32'(state_a), 32'd1);
        tick();
        check("rp_wait", 32'(state_a), 32'd2);
        check("rp_irq",  32'(irq_cnt[0]), 32'd0);
        do_abort();

        // Randomized traffic with changing configuration
        for (int r = 0; r < 4; r++) begin
            int base;
            base = int'($urandom_range(0, 400)) - 200;
            cfg_level = 16'(base);
            for (int c = 0; c < 300; c++) begin
                adc_valid   = ($urandom_range(0, 3) != 0);
                adc_data    = 16'(base + int'($urandom_range(0, 40)) - 20);
                if ($urandom_range(0, 3) == 0) ext_trig = ~ext_trig;
                cfg_sw_trig = ($urandom_range(0, 19) == 0);
                cfg_abort   = ($urandom_range(0, 149) == 0);
                cfg_arm     = ($urandom_range(0, 14) == 0);
                if ($urandom_range(0, 9) == 0) begin
                    cfg_trig_src = 2'($urandom_range(0, 3));
                    cfg_pretrig  = 12'($urandom_range(0, 20));
                    cfg_posttrig = 12'($urandom_range(0, 20));
                    cfg_level    = 16'(base + int'($urandom_range(0, 10)) - 5);
                end
                rstn = ($urandom_range(0, 399) != 0);
                tick();
            end
        end
        rstn = 1'b1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
